mod_counter: RTL
================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter width in bits.
REQ-002 The block SHALL have parameter MOD_VAL, default 16, the modulus; count range is 0..MOD_VAL-1; legal values are 2 <= MOD_VAL <= 2^WIDTH.
REQ-003 The block SHALL have parameter RST_VAL, default 0, the count value loaded by reset and clear; legal values are 0..MOD_VAL-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up_down, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-008 The block SHALL have port sat, input, 1 bit: boundary mode, 1 = saturate, 0 = wrap.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear to RST_VAL.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-012 The block SHALL have port cnt, output, WIDTH bits: the registered count.
REQ-013 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-014 The block SHALL have port wrap, output, 1 bit: registered one-cycle wrap pulse.
REQ-015 The block SHALL have port ovf, output, 1 bit: registered sticky boundary-event flag.

Function
REQ-016 The block SHALL apply this per-edge priority: clr, then load, then en-count, then hold.
REQ-017 clr=1 SHALL set cnt=RST_VAL, wrap=0, ovf=0, regardless of en and load.
REQ-018 load=1 with clr=0 SHALL set cnt=load_val; load_val >= MOD_VAL SHALL be clamped to MOD_VAL-1; load SHALL take effect regardless of en; wrap=0 and ovf unchanged.
REQ-019 en=0 with clr=0 and load=0 SHALL hold cnt; wrap=0; ovf unchanged.
REQ-020 Up count with en=1 and cnt < MOD_VAL-1 SHALL give cnt+1.
REQ-021 Up count with en=1 and cnt = MOD_VAL-1 SHALL give: sat=0 -> cnt=0 and wrap=1 for the next cycle; sat=1 -> cnt held at MOD_VAL-1 and wrap=0.
REQ-022 Down count with en=1 and cnt > 0 SHALL give cnt-1.
REQ-023 Down count with en=1 and cnt = 0 SHALL give: sat=0 -> cnt=MOD_VAL-1 and wrap=1; sat=1 -> cnt held at 0 and wrap=0.
REQ-024 A boundary event is any enabled step attempted from the terminal value (REQ-021/REQ-023) in either mode; each boundary event SHALL set ovf=1, which SHALL stay set until clr or reset.
REQ-025 wrap SHALL be high for exactly one cycle per wrap event; consecutive wraps (MOD_VAL=2, continuous count) SHALL keep wrap high on every such cycle.
REQ-026 tc SHALL equal (up_down ? cnt==MOD_VAL-1 : cnt==0), combinational and independent of en and sat.
REQ-027 up_down and sat MAY change on any cycle; they SHALL take effect at the same edge and never corrupt cnt.
REQ-028 Next-count arithmetic SHALL be WIDTH+1 bits wide so that MOD_VAL = 2^WIDTH never overflows; cnt SHALL never leave 0..MOD_VAL-1.
REQ-029 Latency: every input SHALL affect cnt, wrap and ovf at the first rising clk edge after it is sampled; tc SHALL follow cnt and up_down within the same cycle.

Reset
REQ-030 n_rst=0 SHALL immediately, without a clock edge, force cnt=RST_VAL, wrap=0, ovf=0.
REQ-031 While n_rst=0 the block SHALL ignore all other inputs.
REQ-032 After n_rst goes 1, the first state change SHALL occur at the first rising clk edge; reset mid-count SHALL discard any in-progress value.

Verification (WIDTH=4, MOD_VAL=10, RST_VAL=0)
REQ-033 Reset, then up, en=1, sat=0 for 12 edges -> cnt 1..9, 0, 1, 2; wrap high only in the cycle after 9->0; ovf=1; tc=1 while cnt=9.
REQ-034 clr, then down, en=1, sat=0 from 0 -> cnt 9, 8, 7; wrap pulses once; tc=1 at cnt=0 before the first edge.
REQ-035 sat=1, load 8, up for 4 edges -> cnt 9, 9, 9, 9; wrap stays 0; ovf=1 after the second edge; then down for 2 edges -> 8, 7.
REQ-036 load_val=13 -> cnt=9; load and clr asserted together -> cnt=0 and ovf=0; en=0 with load=1 -> value loaded.
REQ-037 Assert n_rst=0 mid-cycle at cnt=5 -> cnt=0, wrap=0, ovf=0 before the next edge; release it on a negedge -> counting resumes at the next rising edge.
REQ-038 A second instance with MOD_VAL=16 and WIDTH=4, counting up from 15, sat=0 -> cnt=0 and wrap=1, with no X or out-of-range value.

Source files
------------

// File: rtl/mod_counter.sv
// Up/down modulo counter with saturate-or-wrap boundary handling,
// synchronous clear/load, wrap pulse and sticky boundary flag.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MOD_VAL = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam int unsigned MAXI = MOD_VAL - 1;
  localparam int unsigned RSTI = RST_VAL;
  localparam logic [WIDTH:0] MAX_W = MAXI[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_C = MAXI[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_C = RSTI[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH:0]   nxt;
  logic             bnd;

  assign cnt_ext = {1'b0, cnt_q};
  assign lv_ext  = {1'b0, load_val};

  // An underflow from 0 lands on all-ones, so one compare flags both ends
  assign nxt = up_down ? cnt_ext + 1'b1 : cnt_ext - 1'b1;
  assign bnd = nxt > MAX_W;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = RST_C;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (lv_ext > MAX_W) ? MAX_C : load_val;
    end else if (en) begin
      if (bnd) begin
        ovf_d = 1'b1;
        if (!sat) begin
          cnt_d  = up_down ? '0 : MAX_C;
          wrap_d = 1'b1;
        end
      end else begin
        cnt_d = nxt[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= RST_C;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = up_down ? (cnt_ext == MAX_W) : (cnt_q == '0);

endmodule
